// File: rtl/bp_resolve.sv
// Branch resolution: mispredict detection, registered fetch redirect and a 4-entry
// predictor update FIFO. Optional perf counters under BP_RESOLVE_PERF_COUNTERS_EN.
module bp_resolve (
  input  logic        clk,
  input  logic        rst,
  input  logic        res_valid,
  input  logic [15:0] res_pc,
  input  logic [15:0] res_target,
  input  logic        res_taken,
  input  logic        res_uncond,
  input  logic        res_pred_taken,
  input  logic        upd_ready,
  output logic        redirect_valid,
  output logic [15:0] redirect_pc,
  output logic        upd_valid,
  output logic [15:0] upd_pc,
  output logic [15:0] upd_target,
  output logic        upd_taken,
  output logic        res_stall
`ifdef BP_RESOLVE_PERF_COUNTERS_EN
  ,
  output logic [15:0] perf_branches,
  output logic [15:0] perf_mispredicts
`endif
);

  logic        eff_taken;
  logic        mispredict;
  logic        accept;
  logic        enq_req;
  logic        enq;
  logic        deq;
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;
  logic [15:0] mem_pc  [4];
  logic [15:0] mem_tgt [4];
  logic [3:0]  mem_tkn;

  // A resolution arriving alongside a redirect is on the wrong path and is ignored.
  assign eff_taken  = res_taken | res_uncond;
  assign mispredict = eff_taken ^ res_pred_taken;
  assign accept     = res_valid & ~redirect_valid;
  assign enq_req    = accept & (eff_taken | mispredict);
  assign res_stall  = (count == 3'd4);
  assign enq        = enq_req & ~res_stall;
  assign upd_valid  = (count != 3'd0);
  assign deq        = upd_valid & upd_ready;

  assign upd_pc     = mem_pc[rd_ptr];
  assign upd_target = mem_tgt[rd_ptr];
  assign upd_taken  = mem_tkn[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= 16'h0000;
      wr_ptr         <= 2'd0;
      rd_ptr         <= 2'd0;
      count          <= 3'd0;
    end else begin
      redirect_valid <= accept & mispredict;
      if (accept & mispredict)
        redirect_pc <= eff_taken ? res_target : res_pc + 16'd2;
      if (enq)
        wr_ptr <= wr_ptr + 2'd1;
      if (deq)
        rd_ptr <= rd_ptr + 2'd1;
      case ({enq, deq})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset; the count qualifies every read.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_pc[wr_ptr]  <= res_pc;
      mem_tgt[wr_ptr] <= res_target;
      mem_tkn[wr_ptr] <= eff_taken;
    end
  end

`ifdef BP_RESOLVE_PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branches    <= 16'h0000;
      perf_mispredicts <= 16'h0000;
    end else begin
      if (accept && perf_branches != 16'hFFFF)
        perf_branches <= perf_branches + 16'd1;
      if (accept && mispredict && perf_mispredicts != 16'hFFFF)
        perf_mispredicts <= perf_mispredicts + 16'd1;
    end
  end
`endif

endmodule
